// File: rtl/spi_fifo_rx_v2.sv
`default_nettype none
// ============================================================================
// Module   : spi_fifo_rx_v2
// Purpose  : Show-ahead receive FIFO between the SPI shift engine and the
//            register interface. It provides an occupancy count, threshold
//            flags and sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module spi_fifo_rx_v2 #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wen,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       ren,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;

    localparam logic [c_CNT_W-1:0] c_FULL_CNT   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AFULL_CNT  = c_CNT_W'(AFULL_TH);
    localparam logic [c_CNT_W-1:0] c_AEMPTY_CNT = c_CNT_W'(AEMPTY_TH);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wptr;
    logic [c_ADDR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_overflow;
    logic                r_underflow;

    logic w_rd_ok;
    logic w_wr_ok;
    logic w_ovf_evt;
    logic w_unf_evt;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_rd_ok   = ren & ~empty;
    assign w_wr_ok   = wen & (~full | w_rd_ok);
    assign w_ovf_evt = ~flush & wen & ~w_wr_ok;
    assign w_unf_evt = ~flush & ren & empty;

    assign full         = (r_count == c_FULL_CNT);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= c_AFULL_CNT);
    assign almost_empty = (r_count <= c_AEMPTY_CNT);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign rdata        = r_mem[r_rptr];

    // Storage is intentionally not reset; rdata is meaningless while empty.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_wr_ok) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_evt) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
